debounced_counter_display: RTL and testbench
============================================

Name: debounced_counter_display

Overview:
- Parametrised successor to the single-button debounced counter.
- Two raw pushbuttons (up, down) are synchronised and debounced with a clock-enable tick; no derived clocks.
- Drives a wrap-around modulo counter with synchronous clear and hold.
- Renders the count on DIGITS seven-segment digits, in decimal (BCD shadow counter) or hex, selected at run time.

Parameters:
- WIDTH, 8, counter width in bits.
- DIGITS, 2, number of 7-segment digits driven.
- MAX_COUNT, 99, terminal count. Legal only if MAX_COUNT < 2^WIDTH, MAX_COUNT < 10^DIGITS and WIDTH <= 4*DIGITS; otherwise elaboration fails.
- TICK_DIV, 50000, clk cycles per debounce sample tick (>= 2).
- DB_SAMPLES, 8, consecutive differing ticks required to change the debounced state (>= 1).
- SEG_ACTIVE_LOW, 1, 1 inverts all segment outputs (common anode).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_up  in  1  raw button, asynchronous, high = pressed
- btn_down  in  1  raw button, asynchronous, high = pressed
- clr  in  1  synchronous clear, level-sensitive
- hold  in  1  1 = ignore press pulses
- sel  in  1  0 = decimal display, 1 = hex display
- counter  out  WIDTH  binary count
- segmentos  out  7*DIGITS  digit k at bits [7k+6:7k], k=0 is units; bit order g..a
- up_pulse  out  1  one-cycle debounced up-press strobe
- down_pulse  out  1  one-cycle debounced down-press strobe
- wrap  out  1  one-cycle strobe on wrap in either direction

Behaviour:
- Reset (reset=0, async): all state cleared.
  - tick divider 0; synchronisers 0; debounced states 0; debounce counters 0.
  - counter 0; BCD shadow 0; pulses and wrap 0.
  - segmentos shows all digits as "0" with polarity applied.
- Synchroniser: two flops per button; debounce logic sees only the second flop.
- Tick: divider counts 0..TICK_DIV-1; tick asserted for one cycle when the divider is at TICK_DIV-1.
- Debounce, per channel, evaluated on tick cycles only:
  - Sample equal to the stable state: db_cnt <= 0.
  - Sample differs and db_cnt == DB_SAMPLES-1: stable <= sample, db_cnt <= 0.
  - Otherwise: db_cnt++.
  - A bounce (sample returning to the stable state) restarts the count.
- Press pulse: registered; high for exactly one clk cycle, the cycle after stable goes 0->1. Releases produce no pulse.
- A button held through reset yields one press after debounce completes.
- Counter update, on a clk edge where pulses are sampled; priority order:
  1. clr=1: counter <= 0, BCD <= 0, wrap 0. Overrides pulses and hold.
  2. hold=1, or up_pulse and down_pulse both high: no change.
  3. up_pulse: at MAX_COUNT go to 0, BCD to 0, wrap=1; else +1, BCD +1 with decimal carry.
  4. down_pulse: at 0 go to MAX_COUNT, BCD to the elaboration-time BCD constant of MAX_COUNT, wrap=1; else -1, BCD -1 with decimal borrow.
- Latency: pulse high in cycle N -> counter/wrap updated at cycle N+1 -> segmentos updated at N+2. segmentos is registered.
- Display source:
  - sel=0: digit k = BCD digit k.
  - sel=1: digit k = nibble k of counter; nibbles above WIDTH read 0.
  - A sel change is reflected one cycle later.
- Glyphs (gfedcba, active-high before inversion): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- No leading-zero blanking.
- Reset mid-debounce or mid-pulse: immediate clear; no pulse is emitted afterwards for the interrupted press.

Decomposition:
- Package debounced_counter_pkg holds:
  - the 16-entry glyph constant;
  - the function converting an integer to a packed BCD constant (for MAX_COUNT);
  - the parameter-legality check function.
- Sub-module debounce_channel is instantiated twice. It contains the 2-FF synchroniser, db_cnt and stable state, plus the press-pulse register, and takes tick as an input.
- The tick divider, counter, BCD shadow and segment encoding stay in the top module.

Test Plan:
- Bench parameters: TICK_DIV=4, DB_SAMPLES=3, MAX_COUNT=99, DIGITS=2.
- Reset and clean press: release reset; hold btn_up high for 20 ticks -> exactly one up_pulse; counter 0->1; segmentos units=0000110, tens=0111111 (inverted when SEG_ACTIVE_LOW=1); counter update 1 cycle after the pulse, segments 2 cycles after.
- Bounce rejection: toggle btn_up every tick for 10 ticks, then leave it low -> no up_pulse; counter unchanged.
- Wrap both ways:
  - counter=99, up press -> counter 0, wrap one cycle, both digits "0".
  - Then down press -> counter 99, wrap, digits "9""9".
- Decimal vs hex: reach counter=42; sel=0 -> "4""2"; sel=1 -> "2""A", i.e. 0x2A.
- Simultaneous events:
  - up_pulse and down_pulse in the same cycle -> no change.
  - clr=1 coinciding with up_pulse -> counter 0.
  - hold=1 during a press -> no change, but up_pulse is still emitted.
- Async reset mid-debounce: assert reset after 2 of 3 qualifying ticks -> outputs cleared immediately. Deassert with the button low -> no pulse ever.

Source files
------------

// File: rtl/debounced_counter_pkg.sv
// Shared constants and elaboration-time helpers for the debounced counter display.
// Holds the glyph table, a decimal-to-BCD converter and the parameter legality check.
package debounced_counter_pkg;

  // Active-high gfedcba glyphs for hex digits 0..F, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  function automatic logic [63:0] to_bcd(input int unsigned value);
    logic [63:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int width, input int digits, input int max_count,
                                      input int tick_div, input int db_samples);
    longint p10;
    p10 = 1;
    for (int i = 0; i < digits && i < 18; i++) p10 = p10 * 10;
    return (width >= 1) && (width <= 31) && (digits >= 1) && (digits <= 16) &&
           (max_count >= 0) && (longint'(max_count) < (longint'(1) << width)) &&
           (longint'(max_count) < p10) && (width <= 4 * digits) &&
           (tick_div >= 2) && (db_samples >= 1);
  endfunction

endpackage

// File: rtl/debounced_counter_display_debounce_channel.sv
// One pushbutton channel: 2-FF synchroniser, tick-sampled debouncer and press strobe.
module debounce_channel #(
  parameter int DB_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DB_SAMPLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic          sample;

  assign sample = sync_q[1];

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (tick_i) begin
      if (sample == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == CW'(DB_SAMPLES - 1)) begin
        stable_d = sample;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
    // Strobe only on the press edge; releases fall through silently.
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/debounced_counter_display.sv
// Up/down debounced modulo counter with a BCD shadow, shown on DIGITS seven-segment
// digits in decimal or hex. Segment outputs are registered one cycle behind the count.
module debounced_counter_display
  import debounced_counter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 2,
  parameter int MAX_COUNT      = 99,
  parameter int TICK_DIV       = 50000,
  parameter int DB_SAMPLES     = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  clr,
  input  logic                  hold,
  input  logic                  sel,
  output logic [WIDTH-1:0]      counter,
  output logic [7*DIGITS-1:0]   segmentos,
  output logic                  up_pulse,
  output logic                  down_pulse,
  output logic                  wrap
);

  if (!params_legal(WIDTH, DIGITS, MAX_COUNT, TICK_DIV, DB_SAMPLES)) begin : g_illegal
    $error("debounced_counter_display: illegal parameter combination");
  end

  localparam int             TW       = $clog2(TICK_DIV);
  localparam int             BW       = 4 * DIGITS;
  localparam logic [BW-1:0]  BCD_MAX  = BW'(to_bcd(MAX_COUNT));
  localparam logic [6:0]     SEG_ZERO = (SEG_ACTIVE_LOW != 0) ? ~SEG_GLYPHS[0] : SEG_GLYPHS[0];

  logic [TW-1:0]       div_q;
  logic                tick;
  logic [WIDTH-1:0]    counter_q, counter_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_inc, bcd_dec;
  logic                wrap_q, wrap_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [BW-1:0]       hex_src;

  assign tick = (div_q == TW'(TICK_DIV - 1));

  debounce_channel #(.DB_SAMPLES(DB_SAMPLES)) u_up (
    .clk(clk), .rst_n(reset), .tick_i(tick), .btn_i(btn_up), .pulse_o(up_pulse)
  );

  debounce_channel #(.DB_SAMPLES(DB_SAMPLES)) u_down (
    .clk(clk), .rst_n(reset), .tick_i(tick), .btn_i(btn_down), .pulse_o(down_pulse)
  );

  // Decimal ripple carry/borrow across the BCD digits.
  always_comb begin
    logic carry, borrow;
    bcd_inc = bcd_q;
    bcd_dec = bcd_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    counter_d = counter_q;
    bcd_d     = bcd_q;
    wrap_d    = 1'b0;
    if (clr) begin
      counter_d = '0;
      bcd_d     = '0;
    end else if (hold || (up_pulse && down_pulse)) begin
      counter_d = counter_q;
    end else if (up_pulse) begin
      if (counter_q == WIDTH'(MAX_COUNT)) begin
        counter_d = '0;
        bcd_d     = '0;
        wrap_d    = 1'b1;
      end else begin
        counter_d = counter_q + WIDTH'(1);
        bcd_d     = bcd_inc;
      end
    end else if (down_pulse) begin
      if (counter_q == '0) begin
        counter_d = WIDTH'(MAX_COUNT);
        bcd_d     = BCD_MAX;
        wrap_d    = 1'b1;
      end else begin
        counter_d = counter_q - WIDTH'(1);
        bcd_d     = bcd_dec;
      end
    end
  end

  assign hex_src = BW'(counter_q);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    assign nib = sel ? hex_src[4*gi +: 4] : bcd_q[4*gi +: 4];
    assign seg_d[7*gi +: 7] = (SEG_ACTIVE_LOW != 0) ? ~SEG_GLYPHS[nib] : SEG_GLYPHS[nib];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      counter_q <= '0;
      bcd_q     <= '0;
      wrap_q    <= 1'b0;
      seg_q     <= {DIGITS{SEG_ZERO}};
    end else begin
      div_q     <= tick ? '0 : div_q + TW'(1);
      counter_q <= counter_d;
      bcd_q     <= bcd_d;
      wrap_q    <= wrap_d;
      seg_q     <= seg_d;
    end
  end

  assign counter   = counter_q;
  assign wrap      = wrap_q;
  assign segmentos = seg_q;

endmodule

// File: tb/tb_debounced_counter_display.sv
// Directed bench for debounced_counter_display with a fast tick and short debounce.
module tb_debounced_counter_display;

  localparam logic [6:0] G0 = 7'b0111111;
  localparam logic [6:0] G1 = 7'b0000110;
  localparam logic [6:0] G2 = 7'b1011011;
  localparam logic [6:0] G4 = 7'b1100110;
  localparam logic [6:0] G9 = 7'b1101111;
  localparam logic [6:0] GA = 7'b1110111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, clr = 1'b0, hold = 1'b0, sel = 1'b0;
  logic [7:0]  counter;
  logic [13:0] segmentos;
  logic        up_pulse, down_pulse, wrap;

  int errors = 0;
  int checks = 0;
  int up_cnt = 0;
  int dn_cnt = 0;

  debounced_counter_display #(
    .WIDTH(8), .DIGITS(2), .MAX_COUNT(99), .TICK_DIV(4), .DB_SAMPLES(3), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .clr(clr),
    .hold(hold), .sel(sel), .counter(counter), .segmentos(segmentos),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (up_pulse === 1'b1) up_cnt++;
    if (down_pulse === 1'b1) dn_cnt++;
  end

  function automatic logic [13:0] segs(input logic [6:0] tens, input logic [6:0] units);
    return ~{tens, units};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit up, input bit dn, input logic [7:0] exp_cnt,
                       input bit exp_wrap, input logic [13:0] prev_seg,
                       input logic [13:0] exp_seg, input int hold_extra, input string tag);
    bit found;
    found = 1'b0;
    btn_up = up;
    btn_down = dn;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if ((up ? up_pulse : down_pulse) === 1'b1) found = 1'b1;
    end
    check({tag, " pulse seen"}, 32'(found), 32'd1);
    if (found) begin
      check({tag, " pulse pair"}, {30'd0, up_pulse, down_pulse}, {30'd0, up, dn});
      @(negedge clk);
      check({tag, " counter"}, 32'(counter), 32'(exp_cnt));
      check({tag, " wrap"}, 32'(wrap), 32'(exp_wrap));
      check({tag, " seg lag"}, 32'(segmentos), 32'(prev_seg));
      check({tag, " pulse width"}, 32'(up_pulse | down_pulse), 32'd0);
      @(negedge clk);
      check({tag, " seg"}, 32'(segmentos), 32'(exp_seg));
      check({tag, " wrap clear"}, 32'(wrap), 32'd0);
    end
    repeat (hold_extra) @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic quick_up();
    bit found;
    found = 1'b0;
    btn_up = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (up_pulse === 1'b1) found = 1'b1;
    end
    check("quick up pulse", 32'(found), 32'd1);
    btn_up = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int saved_up;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset counter", 32'(counter), 32'd0);
    check("reset seg", 32'(segmentos), 32'(segs(G0, G0)));
    check("reset up_pulse", 32'(up_pulse), 32'd0);
    check("reset down_pulse", 32'(down_pulse), 32'd0);
    check("reset wrap", 32'(wrap), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Clean press held for 20 ticks: one pulse only
    press(1, 0, 8'd1, 0, segs(G0, G0), segs(G0, G1), 80, "clean up");
    check("clean up pulse count", 32'(up_cnt), 32'd1);

    // Bounce: toggle every tick for 10 ticks
    for (int i = 0; i < 10; i++) begin
      btn_up = ~btn_up;
      repeat (4) @(negedge clk);
    end
    btn_up = 1'b0;
    repeat (50) @(negedge clk);
    check("bounce pulse count", 32'(up_cnt), 32'd1);
    check("bounce counter", 32'(counter), 32'd1);

    // Wrap in both directions
    press(0, 1, 8'd0, 0, segs(G0, G1), segs(G0, G0), 0, "down 1->0");
    press(0, 1, 8'd99, 1, segs(G0, G0), segs(G9, G9), 0, "down 0->99");
    press(1, 0, 8'd0, 1, segs(G9, G9), segs(G0, G0), 0, "up 99->0");
    press(0, 1, 8'd99, 1, segs(G0, G0), segs(G9, G9), 0, "down again 0->99");
    check("down pulse count", 32'(dn_cnt), 32'd3);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr counter", 32'(counter), 32'd0);
    @(negedge clk);
    check("clr seg", 32'(segmentos), 32'(segs(G0, G0)));

    // Decimal vs hex at 42
    for (int i = 0; i < 42; i++) quick_up();
    check("count 42", 32'(counter), 32'd42);
    check("dec 42 seg", 32'(segmentos), 32'(segs(G4, G2)));
    sel = 1'b1;
    @(negedge clk);
    check("hex 2A seg", 32'(segmentos), 32'(segs(G2, GA)));
    sel = 1'b0;
    @(negedge clk);
    check("back to dec seg", 32'(segmentos), 32'(segs(G4, G2)));

    // Simultaneous up and down
    press(1, 1, 8'd42, 0, segs(G4, G2), segs(G4, G2), 0, "up+down");

    // Hold: pulse still emitted, no count change
    saved_up = up_cnt;
    hold = 1'b1;
    press(1, 0, 8'd42, 0, segs(G4, G2), segs(G4, G2), 0, "hold");
    hold = 1'b0;
    check("hold pulse emitted", 32'(up_cnt), 32'(saved_up + 1));

    // Clear wins over a coincident press
    clr = 1'b1;
    press(1, 0, 8'd0, 0, segs(G0, G0), segs(G0, G0), 0, "clr+up");
    clr = 1'b0;

    press(1, 0, 8'd1, 0, segs(G0, G0), segs(G0, G1), 0, "pre-reset up");

    // Reset in the middle of a debounce
    saved_up = up_cnt;
    btn_up = 1'b1;
    repeat (9) @(negedge clk);
    check("mid-debounce no pulse yet", 32'(up_cnt), 32'(saved_up));
    reset = 1'b0;
    #1;
    check("async reset counter", 32'(counter), 32'd0);
    check("async reset seg", 32'(segmentos), 32'(segs(G0, G0)));
    check("async reset up_pulse", 32'(up_pulse), 32'd0);
    check("async reset wrap", 32'(wrap), 32'd0);
    btn_up = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("no pulse after reset", 32'(up_cnt), 32'(saved_up));
    check("counter after reset", 32'(counter), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
